dma_layer_sched: RTL and testbench

Layer-level sequencer that drives the `DMA` block's `s_op`/`op`/`e_op` command interface. On `start` it loads the layer configuration word, then the expansion and pointwise kernels, then walks the feature-map-input tiles in raster order. Before each tile it programs the tile coordinates and memory offsets, and it hands every loaded tile to the compute array via a ready/ack handshake. It sits between the top-level layer controller and `DMA`, and is the only master of the DMA command port.

---
 rtl/dma_layer_sched_if.sv | 49 ++++
 rtl/dma_layer_sched.sv | 169 ++++++++++++++++
 tb/tb_dma_layer_sched.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_layer_sched_if.sv
// Command and handshake bundle between the layer sequencer, the DMA block and the compute array.
// The master side is the sequencer; the slave side is everything it talks to.
interface dma_layer_sched_if;
    logic        start;
    logic        busy;
    logic        done;
    logic        s_op;
    logic [2:0]  op;
    logic        e_op;
    logic [41:0] inf_conv;
    logic [7:0]  tx_i;
    logic [7:0]  ty_i;
    logic [7:0]  x_mem_i;
    logic [7:0]  y_mem_i;
    logic        tile_ready;
    logic        tile_ack;

    modport master (
        input  start,
        input  e_op,
        input  inf_conv,
        input  tile_ack,
        output busy,
        output done,
        output s_op,
        output op,
        output tx_i,
        output ty_i,
        output x_mem_i,
        output y_mem_i,
        output tile_ready
    );

    modport slave (
        output start,
        output e_op,
        output inf_conv,
        output tile_ack,
        input  busy,
        input  done,
        input  s_op,
        input  op,
        input  tx_i,
        input  ty_i,
        input  x_mem_i,
        input  y_mem_i,
        input  tile_ready
    );
endinterface

// File: rtl/dma_layer_sched.sv
// Layer sequencer: loads config and kernels through DMA, then walks fmi tiles in raster order,
// handing each loaded tile to compute. All outputs come straight from registers.
module dma_layer_sched (
    input logic              clk,
    input logic              rst,
    dma_layer_sched_if.master bus
);
    localparam logic [2:0] OP_INF = 3'd0;
    localparam logic [2:0] OP_KEX = 3'd1;
    localparam logic [2:0] OP_KPW = 3'd2;
    localparam logic [2:0] OP_FMI = 3'd3;

    typedef enum logic [3:0] {
        StIdle,
        StInfReq,
        StInfWait,
        StKexReq,
        StKexWait,
        StKpwReq,
        StKpwWait,
        StFmiReq,
        StFmiWait,
        StCompute,
        StFin
    } state_t;

    state_t     r_state;
    logic       r_busy;
    logic       r_done;
    logic       r_s_op;
    logic [2:0] r_op;
    logic       r_tile_ready;
    // Tile position doubles as the walk counter, so it only moves when FMI_REQ is entered.
    logic [7:0] r_tx;
    logic [7:0] r_ty;
    logic [7:0] r_x_mem;
    logic [7:0] r_y_mem;
    logic [7:0] r_n_tx;
    logic [7:0] r_n_ty;
    logic [7:0] r_step_x;
    logic [7:0] r_step_y;

    logic w_last_x;
    logic w_last_tile;
    logic w_empty;
    logic w_unused_cfg;

    assign w_last_x     = (r_tx == r_n_tx - 8'd1);
    assign w_last_tile  = w_last_x && (r_ty == r_n_ty - 8'd1);
    assign w_empty      = (r_n_tx == 8'd0) || (r_n_ty == 8'd0);
    assign w_unused_cfg = ^bus.inf_conv[41:32];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StIdle;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_s_op       <= 1'b0;
            r_op         <= OP_INF;
            r_tile_ready <= 1'b0;
            r_tx         <= 8'd0;
            r_ty         <= 8'd0;
            r_x_mem      <= 8'd0;
            r_y_mem      <= 8'd0;
            r_n_tx       <= 8'd0;
            r_n_ty       <= 8'd0;
            r_step_x     <= 8'd0;
            r_step_y     <= 8'd0;
        end else begin
            r_s_op <= 1'b0;
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        r_state <= StInfReq;
                        r_busy  <= 1'b1;
                        r_s_op  <= 1'b1;
                        r_op    <= OP_INF;
                        r_tx    <= 8'd0;
                        r_ty    <= 8'd0;
                        r_x_mem <= 8'd0;
                        r_y_mem <= 8'd0;
                    end
                end
                StInfReq: r_state <= StInfWait;
                StInfWait: begin
                    if (bus.e_op) begin
                        r_n_tx   <= bus.inf_conv[7:0];
                        r_n_ty   <= bus.inf_conv[15:8];
                        r_step_x <= bus.inf_conv[23:16];
                        r_step_y <= bus.inf_conv[31:24];
                        r_state  <= StKexReq;
                        r_s_op   <= 1'b1;
                        r_op     <= OP_KEX;
                    end
                end
                StKexReq: r_state <= StKexWait;
                StKexWait: begin
                    if (bus.e_op) begin
                        r_state <= StKpwReq;
                        r_s_op  <= 1'b1;
                        r_op    <= OP_KPW;
                    end
                end
                StKpwReq: r_state <= StKpwWait;
                StKpwWait: begin
                    if (bus.e_op) begin
                        if (w_empty) begin
                            r_state <= StFin;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= StFmiReq;
                            r_s_op  <= 1'b1;
                            r_op    <= OP_FMI;
                        end
                    end
                end
                StFmiReq: r_state <= StFmiWait;
                StFmiWait: begin
                    if (bus.e_op) begin
                        r_state      <= StCompute;
                        r_tile_ready <= 1'b1;
                    end
                end
                StCompute: begin
                    if (bus.tile_ack) begin
                        r_tile_ready <= 1'b0;
                        if (w_last_tile) begin
                            r_state <= StFin;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= StFmiReq;
                            r_s_op  <= 1'b1;
                            r_op    <= OP_FMI;
                            // Offsets accumulate modulo 256 rather than multiplying index by step.
                            if (w_last_x) begin
                                r_tx    <= 8'd0;
                                r_x_mem <= 8'd0;
                                r_ty    <= r_ty + 8'd1;
                                r_y_mem <= r_y_mem + r_step_y;
                            end else begin
                                r_tx    <= r_tx + 8'd1;
                                r_x_mem <= r_x_mem + r_step_x;
                            end
                        end
                    end
                end
                StFin: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.s_op       = r_s_op;
    assign bus.op         = r_op;
    assign bus.tile_ready = r_tile_ready;
    assign bus.tx_i       = r_tx;
    assign bus.ty_i       = r_ty;
    assign bus.x_mem_i    = r_x_mem;
    assign bus.y_mem_i    = r_y_mem;

    a_sop_single : assert property (@(posedge clk) disable iff (rst) r_s_op |=> !r_s_op);
    a_done_fin : assert property (@(posedge clk) disable iff (rst) r_done |-> r_state == StFin);
endmodule

// File: tb/tb_dma_layer_sched.sv
// Scoreboard bench for dma_layer_sched: expected DMA commands and done pulses are queued by the
// stimulus; a negedge monitor pops and compares them whenever the DUT strobes s_op or done.
module tb_dma_layer_sched;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dma_layer_sched_if bus ();
    dma_layer_sched u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        is_done;
        logic [2:0]  op;
        logic [31:0] coord;
    } ev_t;

    ev_t sb[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push_op(input logic [2:0] op, input logic [7:0] tx, input logic [7:0] ty,
                                    input logic [7:0] xm, input logic [7:0] ym);
        ev_t e;
        e.is_done = 1'b0;
        e.op      = op;
        e.coord   = {tx, ty, xm, ym};
        sb.push_back(e);
    endfunction

    function automatic void push_done();
        ev_t e;
        e.is_done = 1'b1;
        e.op      = 3'd0;
        e.coord   = 32'd0;
        sb.push_back(e);
    endfunction

    // DMA and compute models; injections let the stimulus add abusive pulses without a 2nd driver.
    int eop_req = 0, eop_done = 0, ack_req = 0, ack_done = 0;
    bit resp_en = 1'b1;
    bit dma_pend = 1'b0, cmp_pend = 1'b0;
    int dma_cnt = 0, cmp_cnt = 0;

    always @(posedge clk) begin
        #1;
        bus.e_op     = 1'b0;
        bus.tile_ack = 1'b0;
        if (rst || !resp_en) begin
            dma_pend = 1'b0;
            cmp_pend = 1'b0;
        end else begin
            if (dma_pend) begin
                dma_cnt--;
                if (dma_cnt == 0) begin
                    bus.e_op = 1'b1;
                    dma_pend = 1'b0;
                end
            end
            if (bus.s_op) begin
                dma_pend = 1'b1;
                dma_cnt  = 5;
            end
            if (cmp_pend) begin
                cmp_cnt--;
                if (cmp_cnt == 0) begin
                    bus.tile_ack = 1'b1;
                    cmp_pend     = 1'b0;
                end
            end else if (bus.tile_ready) begin
                cmp_pend = 1'b1;
                cmp_cnt  = 4;
            end
        end
        if (eop_req != eop_done) begin
            bus.e_op = 1'b1;
            eop_done++;
        end
        if (ack_req != ack_done) begin
            bus.tile_ack = 1'b1;
            ack_done++;
        end
    end

    // Monitor
    logic p_start = 1'b0, p_eop = 1'b0, p_ack = 1'b0, p_done = 1'b0;
    int   tr_cycles = 0;

    always @(negedge clk) begin
        ev_t e;
        if (!rst) begin
            if (bus.tile_ready) tr_cycles++;
            if (p_done) check("busy_after_done", 32'(bus.busy), 32'd0);
            if (bus.s_op) begin
                check("busy_on_sop", 32'(bus.busy), 32'd1);
                check("ready_low_on_sop", 32'(bus.tile_ready), 32'd0);
                if (bus.op == 3'd0) check("lat_start", 32'(p_start), 32'd1);
                else if (bus.op == 3'd3) check("lat_fmi", 32'(p_eop | p_ack), 32'd1);
                else check("lat_eop", 32'(p_eop), 32'd1);
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_sop: got op %0d, no command expected at %0t",
                             bus.op, $time);
                end else begin
                    e = sb.pop_front();
                    check("kind_sop", 32'(e.is_done), 32'd0);
                    check("op", 32'(bus.op), 32'(e.op));
                    if (e.op == 3'd3)
                        check("tile", {bus.tx_i, bus.ty_i, bus.x_mem_i, bus.y_mem_i}, e.coord);
                end
            end
            if (bus.done) begin
                check("busy_on_done", 32'(bus.busy), 32'd1);
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done, none expected at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    check("kind_done", 32'(e.is_done), 32'd1);
                end
            end
        end
        p_start = bus.start;
        p_eop   = bus.e_op;
        p_ack   = bus.tile_ack;
        p_done  = bus.done;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_start(input logic [41:0] cfg);
        bus.inf_conv = cfg;
        bus.start    = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int k = 0;
        while ((sb.size() != 0 || bus.busy) && k < max_cyc) begin
            tick(1);
            k++;
        end
        n_tests++;
        if (sb.size() != 0 || bus.busy) begin
            n_fail++;
            $display("FAIL drain: got %0d events pending busy=%0b, required 0 and 0 after %0d cycles",
                     sb.size(), bus.busy, k);
            sb.delete();
        end
        tick(2);
    endtask

    task automatic wait_sop(input logic [2:0] op, input logic [7:0] tx, input int max_cyc);
        bit ok = 1'b0;
        for (int k = 0; k < max_cyc && !ok; k++) begin
            tick(1);
            if (bus.s_op && bus.op == op && bus.tx_i == tx) ok = 1'b1;
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL wait_sop: got no op %0d tx %0d, required within %0d cycles", op, tx, max_cyc);
        end
    endtask

    task automatic wait_ready(input int max_cyc);
        bit ok = 1'b0;
        for (int k = 0; k < max_cyc && !ok; k++) begin
            tick(1);
            if (bus.tile_ready) ok = 1'b1;
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL wait_ready: got no tile_ready, required within %0d cycles", max_cyc);
        end
    endtask

    task automatic check_idle(input string name);
        check(name, 32'({bus.busy, bus.done, bus.s_op, bus.op, bus.tile_ready}), 32'd0);
        check({name, "_tile"}, {bus.tx_i, bus.ty_i, bus.x_mem_i, bus.y_mem_i}, 32'd0);
    endtask

    // step_y=8, step_x=16, n_ty=2, n_tx=3
    localparam logic [41:0] CfgBasic = {10'd0, 8'd8, 8'd16, 8'd2, 8'd3};
    localparam logic [41:0] CfgEmpty = {10'd0, 8'd4, 8'd4, 8'd4, 8'd0};
    localparam logic [41:0] CfgWrap  = {10'h3ff, 8'd7, 8'd16, 8'd1, 8'd20};

    task automatic push_basic();
        push_op(3'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        push_op(3'd1, 8'd0, 8'd0, 8'd0, 8'd0);
        push_op(3'd2, 8'd0, 8'd0, 8'd0, 8'd0);
        push_op(3'd3, 8'd0, 8'd0, 8'd0, 8'd0);
        push_op(3'd3, 8'd1, 8'd0, 8'd16, 8'd0);
        push_op(3'd3, 8'd2, 8'd0, 8'd32, 8'd0);
        push_op(3'd3, 8'd0, 8'd1, 8'd0, 8'd8);
        push_op(3'd3, 8'd1, 8'd1, 8'd16, 8'd8);
        push_op(3'd3, 8'd2, 8'd1, 8'd32, 8'd8);
        push_done();
    endtask

    initial begin
        logic [7:0] wrap_xm [20];
        int tr0;
        wrap_xm = '{8'd0, 8'd16, 8'd32, 8'd48, 8'd64, 8'd80, 8'd96, 8'd112, 8'd128, 8'd144,
                    8'd160, 8'd176, 8'd192, 8'd208, 8'd224, 8'd240, 8'd0, 8'd16, 8'd32, 8'd48};
        rst          = 1'b0;
        bus.start    = 1'b0;
        bus.inf_conv = 42'd0;
        #2 rst = 1'b1;
        tick(3);
        check_idle("reset_outs");
        rst = 1'b0;
        tick(20);
        check_idle("idle_20");
        eop_req++;
        ack_req++;
        tick(5);
        check_idle("idle_spurious");

        // Basic layer
        push_basic();
        run_start(CfgBasic);
        wait_idle(400);

        // Empty layer
        tr0 = tr_cycles;
        push_op(3'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        push_op(3'd1, 8'd0, 8'd0, 8'd0, 8'd0);
        push_op(3'd2, 8'd0, 8'd0, 8'd0, 8'd0);
        push_done();
        run_start(CfgEmpty);
        wait_idle(200);
        check("empty_no_ready", 32'(tr_cycles - tr0), 32'd0);

        // Protocol abuse
        push_basic();
        run_start(CfgBasic);
        wait_sop(3'd1, 8'd0, 50);
        tick(1);
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        wait_ready(100);
        eop_req++;
        wait_sop(3'd3, 8'd1, 100);
        tick(1);
        ack_req++;
        wait_idle(400);

        // Offset wrap
        push_op(3'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        push_op(3'd1, 8'd0, 8'd0, 8'd0, 8'd0);
        push_op(3'd2, 8'd0, 8'd0, 8'd0, 8'd0);
        for (int i = 0; i < 20; i++) push_op(3'd3, 8'(i), 8'd0, wrap_xm[i], 8'd0);
        push_done();
        run_start(CfgWrap);
        wait_idle(1000);

        // Reset during FMI_WAIT of tile 2
        push_basic();
        run_start(CfgBasic);
        wait_sop(3'd3, 8'd2, 200);
        resp_en = 1'b0;
        tick(1);
        rst = 1'b1;
        sb.delete();
        tick(2);
        check_idle("midrst_outs");
        rst = 1'b0;
        tick(1);
        eop_req++;
        tick(8);
        check_idle("stale_eop");
        resp_en = 1'b1;
        push_basic();
        run_start(CfgBasic);
        wait_idle(400);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
